sel_op_initiator: RTL and testbench
===================================

Name: sel_op_initiator

Overview:
- Initiator side of the select/op control link: converts a parallel request (read/write) into a framed select/op sequence toward the responder FSM.
- Observes the responder's rw/valid outputs and reports a completion with status.
- Sits between the host-side command logic and the responder FSM on the same clock.

Parameters:
- GAP_CYCLES, default 2: minimum cycles select held low between frames and after reset. Must be ≥2, because the responder resets on 2 idle cycles.
- TIMEOUT_CYCLES, default 8: max cycles waiting for responder valid before aborting. Must be ≥1.
- CNT_W, default $clog2(max(GAP_CYCLES,TIMEOUT_CYCLES)+1): internal counter width. Local, derived.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- req_valid  input  1  host request present
- req_rw  input  1  requested op: 1=write, 0=read
- req_ready  output  1  initiator can accept request this cycle
- select  output  1  frame enable to responder
- op  output  1  op line to responder
- rsp_rw  input  1  responder rw output
- rsp_valid  input  1  responder valid output
- done  output  1  one-cycle completion pulse
- done_rw  output  1  rw of completed request, held until next done
- err_mismatch  output  1  with done: responder rw ≠ req_rw
- err_timeout  output  1  with done: no valid within TIMEOUT_CYCLES

Behaviour:
- Reset (rst_n=0 at edge): state=GAP, counter=0; outputs select=0, op=0, req_ready=0, done=0, done_rw=0, err_mismatch=0, err_timeout=0.
- Reset mid-frame: select and op are 0 from the next edge. The request is dropped with no done.
- All outputs are registered. No combinational path from inputs to outputs.
- States: GAP, READY, SEND, WAIT, DONE.
- GAP:
  - select=0, op=0.
  - Counter increments each cycle.
  - After GAP_CYCLES cycles in GAP, go to READY. req_ready=1 from the first READY cycle.
- READY:
  - req_ready=1, select=0.
  - On req_valid & req_ready at edge N: latch req_rw, deassert req_ready, go to SEND.
- SEND (one cycle, from edge N):
  - select=1, op=latched rw.
  - Next state WAIT with counter=0.
- WAIT:
  - select=1, op=0.
  - At each edge, sample rsp_valid.
    - If 1: go to DONE; err_mismatch = (rsp_rw ≠ latched rw); err_timeout=0.
    - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES without valid: go to DONE with err_timeout=1, err_mismatch=0.
  - rsp_valid has priority over timeout on the same edge.
- DONE (one cycle):
  - done=1, done_rw=latched rw, select=0, op=0.
  - err flags are valid only while done=1 and are 0 otherwise.
  - Next state GAP with counter=0.
- Latency: select rises the cycle after acceptance. With the responder asserting valid in the first WAIT cycle, done is high 3 cycles after acceptance.
- Back-to-back: req_ready reasserts only after the GAP_CYCLES gap. The minimum frame-to-frame period is 3+GAP_CYCLES+1 cycles.
- rsp_valid/rsp_rw are ignored outside WAIT.
- req_valid is ignored outside READY.

Decomposition:
- Shared package sel_op_pkg holds:
  - state enum (GAP, READY, SEND, WAIT, DONE);
  - OP_READ=1'b0 and OP_WRITE=1'b1;
  - default GAP_CYCLES and TIMEOUT_CYCLES constants.
- One natural sub-module: sel_op_timer. It is a loadable down/up counter with clear and terminal-count flag, shared by GAP and WAIT.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then 1 → select=0, op=0, req_ready rises exactly 2 cycles after reset release. done never asserts.
- Write, responder valid with rw=1 in first WAIT cycle:
  - req_valid=1, req_rw=1 accepted at edge N → select=1 and op=1 at N+1.
  - op=0 at N+2.
  - done=1, done_rw=1, err_mismatch=0, err_timeout=0 at N+3.
  - select=0 at N+3.
- Read with mismatch: req_rw=0, responder returns valid=1, rw=1 → done=1, done_rw=0, err_mismatch=1, err_timeout=0.
- Timeout: rsp_valid held 0 with TIMEOUT_CYCLES=8 → select high for 1+8 cycles, then done=1 with err_timeout=1.
- Valid on timeout edge: rsp_valid=1 exactly at the 8th WAIT edge → err_timeout=0 and done with normal status.
- Reset mid-WAIT plus back-to-back:
  - rst_n=0 during WAIT → select=0 next cycle, no done.
  - Two consecutive held requests → second acceptance ≥ GAP_CYCLES cycles after the first done.

Source files
------------

// File: rtl/sel_op_pkg.sv
// Shared types and constants for the select/op initiator and its timer.
package sel_op_pkg;

  typedef enum logic [2:0] {
    ST_GAP,
    ST_READY,
    ST_SEND,
    ST_WAIT,
    ST_DONE
  } state_t;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  // Select must idle at least two cycles so the responder resynchronises.
  localparam int unsigned GAP_CYCLES_DEF     = 2;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 8;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sel_op_timer.sv
// Loadable up/down counter with clear and terminal-count compare,
// shared by the inter-frame gap and the response wait.
module sel_op_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  input  logic             up,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear beats load beats step.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      cnt_d = up ? (cnt_q + 1'b1) : (cnt_q - 1'b1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == limit);

endmodule

// File: rtl/sel_op_initiator.sv
// Initiator side of the select/op link: frames one host request as a
// select/op sequence, waits for the responder's valid and reports status.
module sel_op_initiator
  import sel_op_pkg::*;
#(
  parameter int unsigned GAP_CYCLES     = GAP_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_valid,
  input  logic req_rw,
  output logic req_ready,
  output logic select,
  output logic op,
  input  logic rsp_rw,
  input  logic rsp_valid,
  output logic done,
  output logic done_rw,
  output logic err_mismatch,
  output logic err_timeout
);

  localparam int unsigned CNT_W = $clog2(max_u(GAP_CYCLES, TIMEOUT_CYCLES) + 1);
  // Terminal counts are one less than the cycle budget: the decision is
  // taken on the edge that ends the last allowed cycle.
  localparam logic [CNT_W-1:0] GAP_LIM = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t state_q, state_d;
  logic   rw_q, rw_d;
  logic   select_q, select_d;
  logic   op_q, op_d;
  logic   req_ready_q, req_ready_d;
  logic   done_q, done_d;
  logic   done_rw_q, done_rw_d;
  logic   err_mismatch_q, err_mismatch_d;
  logic   err_timeout_q, err_timeout_d;

  logic             tmr_clr;
  logic             tmr_en;
  logic [CNT_W-1:0] tmr_limit;
  logic             tmr_tc;

  sel_op_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmr_clr),
    .load    (1'b0),
    .load_val('0),
    .en      (tmr_en),
    .up      (1'b1),
    .limit   (tmr_limit),
    .tc      (tmr_tc)
  );

  // Next state, timer control and next registered outputs.
  always_comb begin
    state_d        = state_q;
    rw_d           = rw_q;
    err_mismatch_d = 1'b0;
    err_timeout_d  = 1'b0;
    tmr_clr        = 1'b0;
    tmr_en         = 1'b0;
    tmr_limit      = GAP_LIM;

    unique case (state_q)
      ST_GAP: begin
        tmr_en = 1'b1;
        if (tmr_tc) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        tmr_clr = 1'b1;
        if (req_valid && req_ready_q) begin
          rw_d    = req_rw;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        tmr_clr = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        tmr_limit = TO_LIM;
        // A valid on the final allowed edge still completes normally.
        if (rsp_valid) begin
          state_d        = ST_DONE;
          err_mismatch_d = (rsp_rw != rw_q);
        end else if (tmr_tc) begin
          state_d       = ST_DONE;
          err_timeout_d = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_DONE: begin
        tmr_clr = 1'b1;
        state_d = ST_GAP;
      end
      default: begin
        tmr_clr = 1'b1;
        state_d = ST_GAP;
      end
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    select_d    = (state_d == ST_SEND) || (state_d == ST_WAIT);
    op_d        = (state_d == ST_SEND) ? rw_d : OP_READ;
    req_ready_d = (state_d == ST_READY);
    done_d      = (state_d == ST_DONE);
    done_rw_d   = (state_d == ST_DONE) ? rw_q : done_rw_q;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_GAP;
      rw_q           <= OP_READ;
      select_q       <= 1'b0;
      op_q           <= 1'b0;
      req_ready_q    <= 1'b0;
      done_q         <= 1'b0;
      done_rw_q      <= 1'b0;
      err_mismatch_q <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      rw_q           <= rw_d;
      select_q       <= select_d;
      op_q           <= op_d;
      req_ready_q    <= req_ready_d;
      done_q         <= done_d;
      done_rw_q      <= done_rw_d;
      err_mismatch_q <= err_mismatch_d;
      err_timeout_q  <= err_timeout_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign select       = select_q;
  assign op           = op_q;
  assign done         = done_q;
  assign done_rw      = done_rw_q;
  assign err_mismatch = err_mismatch_q;
  assign err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_sel_op_initiator.sv
// Scoreboard bench for sel_op_initiator: expected completions are queued at
// request acceptance and compared whenever done pulses.
module tb_sel_op_initiator;

  localparam int unsigned GAP = 2;
  localparam int unsigned TO  = 8;

  typedef struct packed {
    logic rw;
    logic mism;
    logic tout;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, req_valid, req_rw, req_ready, select, op;
  logic rsp_rw, rsp_valid, done, done_rw, err_mismatch, err_timeout;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc      = 0;
  int unsigned acc_last = 0;
  int unsigned done_last = 0;
  bit          mon_en   = 1'b0;
  exp_t        exp_q[$];
  exp_t        mon_e;

  sel_op_initiator #(
    .GAP_CYCLES    (GAP),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_rw      (req_rw),
    .req_ready   (req_ready),
    .select      (select),
    .op          (op),
    .rsp_rw      (rsp_rw),
    .rsp_valid   (rsp_valid),
    .done        (done),
    .done_rw     (done_rw),
    .err_mismatch(err_mismatch),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Completion monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (mon_en) begin
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_done", 32'(done), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("done_rw", 32'(done_rw), 32'(mon_e.rw));
          check_eq("err_mismatch", 32'(err_mismatch), 32'(mon_e.mism));
          check_eq("err_timeout", 32'(err_timeout), 32'(mon_e.tout));
        end
      end else begin
        check_eq("err_idle", 32'({err_mismatch, err_timeout}), 32'd0);
      end
    end
  end

  // One framed transaction; vld_edge = WAIT edge carrying rsp_valid (0 = never).
  // Called at a negedge; req_valid is raised before req_ready is seen.
  task automatic run_txn(input logic rw, input int unsigned vld_edge, input logic rrw);
    int unsigned w = 0;
    int unsigned sel_cnt = 0;
    int unsigned last_k;
    bit got_done = 1'b0;
    exp_t e;
    req_valid = 1'b1;
    req_rw    = rw;
    rsp_valid = 1'b1;
    rsp_rw    = ~rw;
    while (!req_ready && w < 32) begin
      @(negedge clk);
      w++;
    end
    check_eq("ready_wait", 32'(req_ready), 32'd1);
    if (!req_ready) begin
      req_valid = 1'b0;
      rsp_valid = 1'b0;
      return;
    end
    e.rw   = rw;
    e.mism = (vld_edge != 0) ? (rrw != rw) : 1'b0;
    e.tout = (vld_edge == 0);
    exp_q.push_back(e);
    acc_last = cyc + 1;
    last_k   = (vld_edge != 0) ? vld_edge : TO;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("send_select", 32'(select), 32'd1);
    check_eq("send_op", 32'(op), 32'(rw));
    check_eq("send_ready", 32'(req_ready), 32'd0);
    if (select) sel_cnt++;
    @(negedge clk);
    check_eq("wait_op", 32'(op), 32'd0);
    for (int unsigned k = 1; k <= TO; k++) begin
      if (select) sel_cnt++;
      rsp_valid = (k == vld_edge);
      rsp_rw    = rrw;
      @(negedge clk);
      rsp_valid = 1'b0;
      if (done) begin
        got_done = 1'b1;
        check_eq("done_edge", k, last_k);
        break;
      end
    end
    check_eq("got_done", 32'(got_done), 32'd1);
    check_eq("done_select", 32'(select), 32'd0);
    check_eq("select_cycles", sel_cnt, 1 + last_k);
    done_last = cyc;
  endtask

  initial begin
    int unsigned w;
    int unsigned a1;
    int unsigned d1;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_rw = 1'b0;
    rsp_valid = 1'b0;
    rsp_rw = 1'b0;

    // Reset then idle
    repeat (2) @(negedge clk);
    check_eq("rst_select", 32'(select), 32'd0);
    check_eq("rst_op", 32'(op), 32'd0);
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    check_eq("rst_flags", 32'({done, done_rw, err_mismatch, err_timeout}), 32'd0);
    mon_en = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("ready_after1", 32'(req_ready), 32'd0);
    @(negedge clk);
    check_eq("ready_after2", 32'(req_ready), 32'd1);
    repeat (3) @(negedge clk);

    run_txn(1'b1, 1, 1'b1);   // write, immediate matching valid
    run_txn(1'b0, 1, 1'b1);   // read, responder reports write
    run_txn(1'b1, 0, 1'b1);   // timeout
    run_txn(1'b0, TO, 1'b0);  // valid on the timeout edge
    run_txn(1'b0, 3, 1'b0);   // read, delayed valid

    // Reset during WAIT drops the request
    req_valid = 1'b1;
    req_rw = 1'b1;
    w = 0;
    while (!req_ready && w < 32) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check_eq("midwait_select", 32'(select), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("midrst_select", 32'(select), 32'd0);
    check_eq("midrst_op", 32'(op), 32'd0);
    check_eq("midrst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Back-to-back held requests
    run_txn(1'b1, 1, 1'b1);
    a1 = acc_last;
    d1 = done_last;
    run_txn(1'b0, 1, 1'b0);
    check_eq("b2b_period", acc_last - a1, 3 + GAP + 1);
    check_eq("b2b_gap", 32'(acc_last - d1 >= GAP), 32'd1);

    repeat (3) @(negedge clk);
    check_eq("sb_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
